// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_MEM   = 1'b1
    } owner_e;

    localparam logic [DATA_W-1:0] ERROR_DATA = 32'h0;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_payload_t;

    // On a tie the requester that did not win last time is chosen.
    function automatic owner_e pick_owner(input logic fetch_req, input logic mem_req,
                                          input owner_e last_owner);
        if (fetch_req && mem_req) begin
            return (last_owner == OWN_MEM) ? OWN_FETCH : OWN_MEM;
        end
        return fetch_req ? OWN_FETCH : OWN_MEM;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side, downstream-side and error signals of mem_arbiter.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              fetch_request_enable;
    logic              freq_mode;
    logic [ADDR_W-1:0] freq_addr;
    logic [DATA_W-1:0] freq_wdata;
    logic [STRB_W-1:0] freq_wstrb;
    logic              fetch_response_enable;
    logic [DATA_W-1:0] fresp_data;

    logic              mem_request_enable;
    logic              mreq_mode;
    logic [ADDR_W-1:0] mreq_addr;
    logic [DATA_W-1:0] mreq_wdata;
    logic [STRB_W-1:0] mreq_wstrb;
    logic              mem_response_enable;
    logic [DATA_W-1:0] mresp_data;

    logic              request_enable;
    logic              req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              response_enable;
    logic [DATA_W-1:0] resp_data;

    logic              bus_error;

    modport slave (
        input  fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
        output fetch_response_enable, fresp_data,
        input  mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
        output mem_response_enable, mresp_data,
        output request_enable, req_mode, req_addr, req_wdata, req_wstrb,
        input  response_enable, resp_data,
        output bus_error
    );

    modport master (
        output fetch_request_enable, freq_mode, freq_addr, freq_wdata, freq_wstrb,
        input  fetch_response_enable, fresp_data,
        output mem_request_enable, mreq_mode, mreq_addr, mreq_wdata, mreq_wstrb,
        input  mem_response_enable, mresp_data,
        input  request_enable, req_mode, req_addr, req_wdata, req_wstrb,
        output response_enable, resp_data,
        input  bus_error
    );

endinterface

// File: rtl/mem_arb_req_latch.sv
// Per-requester pending bit and payload register, with a bypass so an idle arbiter can grant a fresh pulse.
module mem_arb_req_latch
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         pulse,
    input  req_payload_t payload,
    input  logic         owns,
    input  logic         grant,
    output logic         eff_req,
    output req_payload_t eff_payload
);

    logic         pending;
    logic         accept;
    req_payload_t payload_q;

    // A pulse while already pending or owning the bus is dropped; the stored payload wins.
    assign accept = pulse && !pending && !owns;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 1'b0;
        end else if (grant) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            payload_q <= payload;
        end
    end

    assign eff_req     = pending || accept;
    assign eff_payload = pending ? payload_q : payload;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store, one transaction in flight.
// Optional ARB_TIMEOUT_EN: forced error response (bus_error) after TIMEOUT_CYCLES in WAIT.
module mem_arbiter
    import mem_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d, last_q, last_d, sel;
    logic              fetch_eff, mem_eff, grant_fetch, grant_mem, fetch_owns, mem_owns;
    req_payload_t      fetch_in, mem_in, fetch_pay, mem_pay, req_q, req_d;
    logic              req_en_q, req_en_d, fresp_en_q, fresp_en_d, mresp_en_q, mresp_en_d;
    logic [DATA_W-1:0] fdata_q, fdata_d, mdata_q, mdata_d, resp_word;
    logic              resp_fire;

    assign fetch_in   = {bus.freq_mode, bus.freq_addr, bus.freq_wdata, bus.freq_wstrb};
    assign mem_in     = {bus.mreq_mode, bus.mreq_addr, bus.mreq_wdata, bus.mreq_wstrb};
    assign fetch_owns = (state_q == WAIT) && (owner_q == OWN_FETCH);
    assign mem_owns   = (state_q == WAIT) && (owner_q == OWN_MEM);

    mem_arb_req_latch u_fetch_latch (
        .clk         (clk),
        .rst         (rst),
        .pulse       (bus.fetch_request_enable),
        .payload     (fetch_in),
        .owns        (fetch_owns),
        .grant       (grant_fetch),
        .eff_req     (fetch_eff),
        .eff_payload (fetch_pay)
    );

    mem_arb_req_latch u_mem_latch (
        .clk         (clk),
        .rst         (rst),
        .pulse       (bus.mem_request_enable),
        .payload     (mem_in),
        .owns        (mem_owns),
        .grant       (grant_mem),
        .eff_req     (mem_eff),
        .eff_payload (mem_pay)
    );

    assign sel = pick_owner(fetch_eff, mem_eff, last_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit, berr_q, berr_d;

    // Counter is held at zero in IDLE, so it restarts on every entry to WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            berr_q   <= 1'b0;
        end else begin
            wait_cnt <= (state_q == IDLE) ? '0 : wait_cnt + CNT_W'(1);
            berr_q   <= berr_d;
        end
    end

    assign timeout_hit   = (state_q == WAIT) && (32'(wait_cnt) == TIMEOUT_CYCLES - 1);
    assign bus.bus_error = berr_q;
`else
    assign bus.bus_error = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant_fetch = 1'b0;
        grant_mem   = 1'b0;
        req_en_d    = 1'b0;
        req_d       = req_q;
        fresp_en_d  = 1'b0;
        mresp_en_d  = 1'b0;
        fdata_d     = fdata_q;
        mdata_d     = mdata_q;
        resp_fire   = 1'b0;
        resp_word   = bus.resp_data;
`ifdef ARB_TIMEOUT_EN
        berr_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (fetch_eff || mem_eff) begin
                    owner_d     = sel;
                    last_d      = sel;
                    grant_fetch = (sel == OWN_FETCH);
                    grant_mem   = (sel == OWN_MEM);
                    req_d       = (sel == OWN_FETCH) ? fetch_pay : mem_pay;
                    req_en_d    = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                resp_fire = bus.response_enable;
`ifdef ARB_TIMEOUT_EN
                if (!bus.response_enable && timeout_hit) begin
                    resp_fire = 1'b1;
                    resp_word = ERROR_DATA;
                    berr_d    = 1'b1;
                end
`endif
                if (resp_fire) begin
                    state_d = IDLE;
                    if (owner_q == OWN_FETCH) begin
                        fresp_en_d = 1'b1;
                        fdata_d    = resp_word;
                    end else begin
                        mresp_en_d = 1'b1;
                        mdata_d    = resp_word;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_FETCH;
            last_q     <= OWN_MEM;
            req_en_q   <= 1'b0;
            req_q      <= '0;
            fresp_en_q <= 1'b0;
            mresp_en_q <= 1'b0;
            fdata_q    <= '0;
            mdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            req_en_q   <= req_en_d;
            req_q      <= req_d;
            fresp_en_q <= fresp_en_d;
            mresp_en_q <= mresp_en_d;
            fdata_q    <= fdata_d;
            mdata_q    <= mdata_d;
        end
    end

    assign bus.request_enable        = req_en_q;
    assign bus.req_mode              = req_q.mode;
    assign bus.req_addr              = req_q.addr;
    assign bus.req_wdata             = req_q.wdata;
    assign bus.req_wstrb             = req_q.wstrb;
    assign bus.fetch_response_enable = fresp_en_q;
    assign bus.fresp_data            = fdata_q;
    assign bus.mem_response_enable   = mresp_en_q;
    assign bus.mresp_data            = mdata_q;

endmodule
